// File: rtl/asm_count_ctrl_if.sv
// Control/observation bundle for asm_count_ctrl: run request and qualifiers in,
// counter and FSM status out.
interface asm_count_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             x;
  logic             abort;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             busy;
  logic             done;

  modport master (
    output start, x, abort, limit,
    input  count, state, busy, done
  );

  modport slave (
    input  start, x, abort, limit,
    output count, state, busy, done
  );
endinterface

// File: rtl/asm_count_ctrl.sv
// Three-state run controller: IDLE -> WAIT -> COUNT, counting x-qualified cycles
// up to a limit captured at start, with abort and a one-cycle done pulse.
module asm_count_ctrl #(
  parameter  int unsigned WIDTH       = 4,
  localparam int unsigned STATE_ENC_W = 2
) (
  input  logic               clock,
  input  logic               clear_n,
  asm_count_ctrl_if.slave    bus
);

  typedef enum logic [STATE_ENC_W-1:0] {
    S_IDLE  = 2'b00,
    S_WAIT  = 2'b01,
    S_COUNT = 2'b10
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_q;
  logic             done_q;

  // Abort outranks the terminal check, which in turn outranks x.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      limit_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_WAIT;
            count_q <= '0;
            limit_q <= bus.limit;
          end
        end
        S_WAIT: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
          end else if (bus.x) begin
            state_q <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
          end else if (count_q == limit_q) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else begin
            count_q <= count_q + WIDTH'(1);
            state_q <= bus.x ? S_COUNT : S_WAIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.state = STATE_ENC_W'(state_q);
  assign bus.done  = done_q;
  assign bus.busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_asm_count_ctrl.sv
// Directed bench for asm_count_ctrl (WIDTH=4): expected state/count/done per edge
// are queued when stimulus is applied and compared after the edge.
module tb_asm_count_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WAIT  = 2'b01;
  localparam logic [1:0] ST_COUNT = 2'b10;

  typedef struct {
    string            tag;
    logic [1:0]       st;
    logic [WIDTH-1:0] cnt;
    logic             dn;
  } exp_t;

  logic clock;
  logic clear_n;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  asm_count_ctrl_if #(.WIDTH(WIDTH)) bus ();

  asm_count_ctrl #(.WIDTH(WIDTH)) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [1:0] st, input logic [WIDTH-1:0] cnt,
                               input logic dn);
    check({tag, ".state"}, 32'(bus.state), 32'(st));
    check({tag, ".count"}, 32'(bus.count), 32'(cnt));
    check({tag, ".done"},  32'(bus.done),  32'(dn));
    check({tag, ".busy"},  32'(bus.busy),  32'(st != ST_IDLE));
  endtask

  // Drive inputs mid-cycle, queue the expectation, compare just after the edge.
  task automatic step(input string tag, input logic s, input logic xi, input logic ab,
                      input logic [WIDTH-1:0] lim, input logic [1:0] est,
                      input logic [WIDTH-1:0] ecnt, input logic edn);
    exp_t e;
    @(negedge clock);
    bus.start = s;
    bus.x     = xi;
    bus.abort = ab;
    bus.limit = lim;
    sb.push_back('{tag, est, ecnt, edn});
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      check_outputs(e.tag, e.st, e.cnt, e.dn);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    clear_n   = 1'b0;
    bus.start = 1'b0;
    bus.x     = 1'b0;
    bus.abort = 1'b0;
    bus.limit = '0;

    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset", ST_IDLE, 4'd0, 1'b0);
    @(negedge clock);
    clear_n = 1'b1;

    // Basic run, limit=3, x held high.
    step("b_e1", 1, 1, 0, 4'd3, ST_WAIT,  4'd0, 0);
    step("b_e2", 0, 1, 0, 4'd3, ST_COUNT, 4'd0, 0);
    step("b_e3", 0, 1, 0, 4'd3, ST_COUNT, 4'd1, 0);
    step("b_e4", 0, 1, 0, 4'd3, ST_COUNT, 4'd2, 0);
    step("b_e5", 0, 1, 0, 4'd3, ST_COUNT, 4'd3, 0);
    step("b_e6", 0, 1, 0, 4'd3, ST_IDLE,  4'd3, 1);
    step("b_e7", 0, 1, 0, 4'd3, ST_IDLE,  4'd3, 0);

    // limit=5 with x dropping mid-count.
    step("x_st",  1, 0, 0, 4'd5, ST_WAIT,  4'd0, 0);
    step("x_w0",  0, 0, 0, 4'd5, ST_WAIT,  4'd0, 0);
    step("x_c0",  0, 1, 0, 4'd5, ST_COUNT, 4'd0, 0);
    step("x_c1",  0, 1, 0, 4'd5, ST_COUNT, 4'd1, 0);
    step("x_w2",  0, 0, 0, 4'd5, ST_WAIT,  4'd2, 0);
    step("x_w2b", 0, 0, 0, 4'd5, ST_WAIT,  4'd2, 0);
    step("x_c2",  0, 1, 0, 4'd5, ST_COUNT, 4'd2, 0);
    step("x_c3",  0, 1, 0, 4'd5, ST_COUNT, 4'd3, 0);
    step("x_c4",  0, 1, 0, 4'd5, ST_COUNT, 4'd4, 0);
    step("x_c5",  0, 1, 0, 4'd5, ST_COUNT, 4'd5, 0);
    step("x_dn",  0, 0, 0, 4'd5, ST_IDLE,  4'd5, 1);
    step("x_end", 0, 0, 0, 4'd5, ST_IDLE,  4'd5, 0);

    // limit=15 reaches all-ones without wrapping, then back-to-back restart.
    step("m_st", 1, 1, 0, 4'd15, ST_WAIT,  4'd0, 0);
    step("m_c0", 0, 1, 0, 4'd15, ST_COUNT, 4'd0, 0);
    for (int i = 1; i <= 15; i++) begin
      step($sformatf("m_c%0d", i), 0, 1, 0, 4'd15, ST_COUNT, 4'(i), 0);
    end
    step("m_dn",  0, 1, 0, 4'd15, ST_IDLE,  4'd15, 1);
    step("m_re",  1, 1, 0, 4'd2,  ST_WAIT,  4'd0,  0);
    step("m_r0",  0, 1, 0, 4'd2,  ST_COUNT, 4'd0,  0);
    step("m_r1",  0, 1, 0, 4'd2,  ST_COUNT, 4'd1,  0);
    step("m_r2",  0, 1, 0, 4'd2,  ST_COUNT, 4'd2,  0);
    step("m_rdn", 0, 1, 0, 4'd2,  ST_IDLE,  4'd2,  1);
    step("m_rend",0, 1, 0, 4'd2,  ST_IDLE,  4'd2,  0);

    // Abort alone in IDLE is inert; start with abort still starts. limit=0.
    step("z_ab",  0, 1, 1, 4'd0, ST_IDLE,  4'd2, 0);
    step("z_st",  1, 1, 1, 4'd0, ST_WAIT,  4'd0, 0);
    step("z_c0",  0, 1, 0, 4'd0, ST_COUNT, 4'd0, 0);
    step("z_dn",  0, 1, 0, 4'd0, ST_IDLE,  4'd0, 1);
    step("z_end", 0, 1, 0, 4'd0, ST_IDLE,  4'd0, 0);

    // Abort at count=2 (limit=7); start/limit wiggles mid-run are ignored.
    step("a_st",  1, 1, 0, 4'd7, ST_WAIT,  4'd0, 0);
    step("a_c0",  1, 1, 0, 4'd0, ST_COUNT, 4'd0, 0);
    step("a_c1",  1, 1, 0, 4'd1, ST_COUNT, 4'd1, 0);
    step("a_c2",  0, 1, 0, 4'd2, ST_COUNT, 4'd2, 0);
    step("a_ab",  0, 1, 1, 4'd2, ST_IDLE,  4'd2, 0);
    step("a_end", 0, 1, 0, 4'd2, ST_IDLE,  4'd2, 0);

    // Abort beats the terminal check (limit=1 at count=1), and abort from WAIT.
    step("t_st",  1, 1, 0, 4'd1, ST_WAIT,  4'd0, 0);
    step("t_c0",  0, 1, 0, 4'd1, ST_COUNT, 4'd0, 0);
    step("t_c1",  0, 1, 0, 4'd1, ST_COUNT, 4'd1, 0);
    step("t_ab",  0, 1, 1, 4'd1, ST_IDLE,  4'd1, 0);
    step("t_end", 0, 0, 0, 4'd1, ST_IDLE,  4'd1, 0);
    step("w_st",  1, 0, 0, 4'd4, ST_WAIT,  4'd0, 0);
    step("w_ab",  0, 1, 1, 4'd4, ST_IDLE,  4'd0, 0);

    // Asynchronous clear mid-COUNT.
    step("r_st", 1, 1, 0, 4'd9, ST_WAIT,  4'd0, 0);
    step("r_c0", 0, 1, 0, 4'd9, ST_COUNT, 4'd0, 0);
    step("r_c1", 0, 1, 0, 4'd9, ST_COUNT, 4'd1, 0);
    step("r_c2", 0, 1, 0, 4'd9, ST_COUNT, 4'd2, 0);
    @(negedge clock);
    clear_n = 1'b0;
    #1;
    check_outputs("r_async", ST_IDLE, 4'd0, 1'b0);
    @(posedge clock);
    #1;
    check_outputs("r_held", ST_IDLE, 4'd0, 1'b0);
    @(negedge clock);
    clear_n = 1'b1;
    step("r_rel1", 0, 1, 0, 4'd9, ST_IDLE, 4'd0, 0);
    step("r_rel2", 0, 1, 0, 4'd9, ST_IDLE, 4'd0, 0);

    // Post-reset run confirms the captured limit was cleared and reloaded.
    step("p_st", 1, 1, 0, 4'd1, ST_WAIT,  4'd0, 0);
    step("p_c0", 0, 1, 0, 4'd1, ST_COUNT, 4'd0, 0);
    step("p_c1", 0, 1, 0, 4'd1, ST_COUNT, 4'd1, 0);
    step("p_dn", 0, 1, 0, 4'd1, ST_IDLE,  4'd1, 1);

    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
